fp32_mul_round_pack: RTL and testbench
======================================

Name: fp32_mul_round_pack

Overview:
- Downstream stage of the FP32 multiplier datapath.
- Consumes the raw 48-bit significand product, biased exponent sum, sign and special-case flags produced by the multiply core.
- Normalizes, rounds to nearest-even and packs an IEEE-754 single-precision result with overflow/underflow/exception flags.
- 2-stage valid/ready pipeline with full backpressure, so the multiplier can be stalled by downstream consumers.

Parameters:
XLEN, 32, result width; only 32 supported
MANT_W, 48, width of unrounded significand product (24x24)
EXP_W, 10, width of signed exponent-sum input

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream product valid
in_ready  output  1  stage can accept product this cycle
in_sign  input  1  product sign (signA ^ signB)
in_exp  input  EXP_W  two's-complement expA+expB-127 (range -125..381)
in_mant  input  MANT_W  product of hidden-bit significands, format 2.46
in_nan  input  1  upstream detected NaN operand or inf*0
in_inf  input  1  upstream detected infinite result
in_zero  input  1  upstream detected zero operand (denormals already flushed)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  XLEN  packed FP32 result
overflow  output  1  finite result exceeded max exponent
underflow  output  1  result flushed to zero (exp <= 0)
exception  output  1  NaN produced

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: s1_valid=0, out_valid=0, result=0, overflow=0, underflow=0, exception=0. in_ready=1 after reset.
- Transfer occurs on a cycle where valid&ready. Latency is exactly 2 cycles from input accept to out_valid with no stalls. Throughput is 1/cycle.
- Stage 1 (normalize), registered on accept:
  - If in_mant[47]=1: frac=in_mant[46:24], guard=in_mant[23], sticky=|in_mant[22:0], exp=in_exp+1.
  - Else: frac=in_mant[45:23], guard=in_mant[22], sticky=|in_mant[21:0], exp=in_exp.
  - If in_mant[47:46]==0 and no special flag is set, treat as zero.
  - Exponent is carried as EXP_W+1 signed so that no wrap occurs.
- Stage 2 (round/pack), registered into output:
  - Round up iff guard & (sticky | frac[0]).
  - A 23-bit carry-out sets frac=0 and exp+=1.
  - Priority:
    - in_nan: 0x7FC00000, exception=1.
    - in_inf: {sign,0xFF,0}, no flags.
    - in_zero: {sign,31'b0}, no flags.
    - exp>=255 after rounding: {sign,0xFF,0}, overflow=1.
    - exp<=0: {sign,31'b0}, underflow=1.
    - else: {sign,exp[7:0],frac}.
  - Flags are sideband of result, meaningful only while out_valid=1. Exactly one of overflow/underflow/exception is set at most.
- Handshake:
  - Output stage loads when !out_valid | out_ready.
  - s1 advances when it is valid and the output stage loads.
  - in_ready = !s1_valid | s1_advance (combinational from out_ready; no skid).
  - While out_valid & !out_ready: result and flags held stable, out_valid held.
  - Ordering is strictly FIFO; no drops or duplicates.
  - Simultaneous output consume and input accept with both stages full: all shift in the same cycle.
- Reset mid-operation: in-flight items are discarded and outputs return to reset values asynchronously. No partial result is emitted after reset release.
- in_* sampled only when in_valid&in_ready; values otherwise ignored (X-tolerant).

Test Plan:
- 9.0 case: in_sign=0, in_exp=129, in_mant=0x900000000000, out_ready=1 -> result=0x41100000 two cycles later, all flags 0.
- Rounding carry: in_exp=127, in_mant=0x7FFFFFC00000 -> result=0x40000000 (2.0). Tie-to-even: in_exp=127, in_mant=0x400000400000 -> 0x3F800000 (not rounded up).
- Overflow/underflow: in_sign=1, in_exp=254, in_mant=0x900000000000 -> 0xFF800000, overflow=1. in_exp=0, in_mant=0x400000000000 -> 0x00000000, underflow=1.
- Specials: in_nan=1 -> 0x7FC00000, exception=1. in_inf=1, sign=1 -> 0xFF800000, no flags. in_zero=1, sign=1 -> 0x80000000, no flags.
- Backpressure: out_ready=0 for 6 cycles while 4 back-to-back products are offered:
  - in_ready falls after 2 are accepted.
  - result stays stable.
  - On out_ready=1, all 4 emerge in order on consecutive cycles.
- Reset: assert rst with both stages full -> out_valid=0 immediately (async). After release, no stale result appears and in_ready=1.

Source files
------------

// File: rtl/fp32_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_round_pack
// Purpose  : Back end of the FP32 multiplier. Takes the raw 2.46 significand
//            product, the biased exponent sum, the sign and the special-case
//            flags. It normalises, rounds to nearest-even and packs an
//            IEEE-754 single-precision result. The stage is a two-deep
//            valid/ready pipeline with full backpressure.
// Ports    : clk, rst             - clock (rising edge), async active-high reset
//            in_valid / in_ready  - upstream handshake
//            in_sign, in_exp,     - product sign, signed exponent sum,
//            in_mant              - 48-bit significand product
//            in_nan/inf/zero      - special-case flags from the multiply core
//            out_valid/out_ready  - downstream handshake
//            result               - packed FP32 value
//            overflow/underflow/  - sideband flags, valid with out_valid
//            exception
// Revision : 1.0 - initial release
// ============================================================================
module fp32_mul_round_pack #(
   parameter int XLEN   = 32,
   parameter int MANT_W = 48,
   parameter int EXP_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   input  logic              in_nan,
   input  logic              in_inf,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              overflow,
   output logic              underflow,
   output logic              exception
);

   localparam int C_FRAC_W = 23;
   localparam int C_S1E_W  = EXP_W + 1;   // normalised exponent, never wraps
   localparam int C_S2E_W  = EXP_W + 2;   // room for the rounding carry too

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic w_out_load;
   logic w_s1_adv;
   logic w_in_fire;

   logic s1_valid_q;
   logic out_valid_q;

   assign w_out_load = !out_valid_q | out_ready;
   assign w_s1_adv   = s1_valid_q & w_out_load;
   assign in_ready   = !s1_valid_q | w_s1_adv;
   assign w_in_fire  = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Stage 1: normalise
   // ------------------------------------------------------------------
   logic                s1_sign_d,   s1_sign_q;
   logic [C_S1E_W-1:0]  s1_exp_d,    s1_exp_q;
   logic [C_FRAC_W-1:0] s1_frac_d,   s1_frac_q;
   logic                s1_guard_d,  s1_guard_q;
   logic                s1_sticky_d, s1_sticky_q;
   logic                s1_nan_d,    s1_nan_q;
   logic                s1_inf_d,    s1_inf_q;
   logic                s1_zero_d,   s1_zero_q;

   logic                w_msb;
   logic [C_S1E_W-1:0]  w_exp_ext;

   assign w_msb     = in_mant[MANT_W-1];
   assign w_exp_ext = {in_exp[EXP_W-1], in_exp};

   always_comb begin
      s1_sign_d = in_sign;
      s1_nan_d  = in_nan;
      s1_inf_d  = in_inf;
      // A product with neither leading bit set can only come from a zero
      // operand; NaN/Inf outrank it at pack time, so no masking is needed.
      s1_zero_d = in_zero | (in_mant[MANT_W-1 -: 2] == 2'b00);
      s1_exp_d  = w_exp_ext + {{EXP_W{1'b0}}, w_msb};
      if (w_msb) begin
         s1_frac_d   = in_mant[MANT_W-2 -: C_FRAC_W];
         s1_guard_d  = in_mant[MANT_W-C_FRAC_W-2];
         s1_sticky_d = |in_mant[MANT_W-C_FRAC_W-3:0];
      end else begin
         s1_frac_d   = in_mant[MANT_W-3 -: C_FRAC_W];
         s1_guard_d  = in_mant[MANT_W-C_FRAC_W-3];
         s1_sticky_d = |in_mant[MANT_W-C_FRAC_W-4:0];
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: round to nearest-even and pack
   // ------------------------------------------------------------------
   logic                w_round_up;
   logic [C_FRAC_W:0]   w_frac_sum;
   logic [C_S2E_W-1:0]  w_exp_rnd;
   logic                w_exp_ovf;
   logic                w_exp_unf;

   logic [XLEN-1:0]     result_d,    result_q;
   logic                overflow_d,  overflow_q;
   logic                underflow_d, underflow_q;
   logic                exception_d, exception_q;

   assign w_round_up = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
   assign w_frac_sum = {1'b0, s1_frac_q} + {{C_FRAC_W{1'b0}}, w_round_up};
   // A carry out of the fraction leaves frac=0 and bumps the exponent.
   assign w_exp_rnd  = {s1_exp_q[C_S1E_W-1], s1_exp_q}
                     + {{C_S1E_W{1'b0}}, w_frac_sum[C_FRAC_W]};
   // exp >= 255: non-negative and either above 8 bits or exactly 0xFF.
   assign w_exp_ovf  = !w_exp_rnd[C_S2E_W-1]
                     & ((|w_exp_rnd[C_S2E_W-2:8]) | (&w_exp_rnd[7:0]));
   // exp <= 0: negative or zero.
   assign w_exp_unf  = w_exp_rnd[C_S2E_W-1] | (w_exp_rnd == '0);

   always_comb begin
      result_d    = {s1_sign_q, w_exp_rnd[7:0], w_frac_sum[C_FRAC_W-1:0]};
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      exception_d = 1'b0;
      if (s1_nan_q) begin
         result_d    = 32'h7FC0_0000;
         exception_d = 1'b1;
      end else if (s1_inf_q) begin
         result_d    = {s1_sign_q, 8'hFF, 23'd0};
      end else if (s1_zero_q) begin
         result_d    = {s1_sign_q, 31'd0};
      end else if (w_exp_ovf) begin
         result_d    = {s1_sign_q, 8'hFF, 23'd0};
         overflow_d  = 1'b1;
      end else if (w_exp_unf) begin
         result_d    = {s1_sign_q, 31'd0};
         underflow_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= '0;
         s1_frac_q   <= '0;
         s1_guard_q  <= 1'b0;
         s1_sticky_q <= 1'b0;
         s1_nan_q    <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_zero_q   <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (w_in_fire) begin
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_frac_q   <= s1_frac_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         exception_q <= 1'b0;
      end else begin
         if (w_out_load) begin
            out_valid_q <= s1_valid_q;
         end
         if (w_s1_adv) begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            exception_q <= exception_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign exception = exception_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_round_pack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fp32_mul_round_pack
// Purpose  : Self-checking bench for fp32_mul_round_pack: directed vector
//            table, backpressure sequence and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_mul_round_pack;

   localparam int NV = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        in_nan;
   logic        in_inf;
   logic        in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        exception;

   always #5 clk = ~clk;

   fp32_mul_round_pack #(
      .XLEN   (32),
      .MANT_W (48),
      .EXP_W  (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_nan    (in_nan),
      .in_inf    (in_inf),
      .in_zero   (in_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .exception (exception)
   );

   typedef struct {
      logic        sign;
      logic [9:0]  exp;
      logic [47:0] mant;
      logic        nan;
      logic        inf;
      logic        zero;
      logic [31:0] res;
      logic        ov;
      logic        uf;
      logic        exc;
   } vec_t;

   vec_t vecs [NV];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [47:0] m,
                               input logic n, input logic i, input logic z,
                               input logic [31:0] r, input logic o, input logic u,
                               input logic x);
      vec_t v;
      v.sign = s; v.exp = e; v.mant = m; v.nan = n; v.inf = i; v.zero = z;
      v.res = r; v.ov = o; v.uf = u; v.exc = x;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      in_sign = v.sign;
      in_exp  = v.exp;
      in_mant = v.mant;
      in_nan  = v.nan;
      in_inf  = v.inf;
      in_zero = v.zero;
   endtask

   // Garbage on the data inputs while idle; the DUT must ignore it.
   task automatic idle();
      in_valid = 1'b0;
      in_sign  = 1'($urandom);
      in_exp   = 10'($urandom);
      in_mant  = {16'($urandom), 32'($urandom)};
      in_nan   = 1'($urandom);
      in_inf   = 1'($urandom);
      in_zero  = 1'($urandom);
   endtask

   task automatic check_out(input string tag, input vec_t v);
      check({tag, " result"},    result,           v.res);
      check({tag, " overflow"},  {31'd0, overflow},  {31'd0, v.ov});
      check({tag, " underflow"}, {31'd0, underflow}, {31'd0, v.uf});
      check({tag, " exception"}, {31'd0, exception}, {31'd0, v.exc});
   endtask

   int   sent;
   int   got;
   int   last_c;
   logic [31:0] held;
   logic        held_valid;

   initial begin
      //              sign  exp       mant               nan   inf   zero  result        ov    uf    exc
      vecs[0]  = mk(1'b0, 10'd129, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h41100000, 1'b0, 1'b0, 1'b0); // 9.0
      vecs[1]  = mk(1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0); // carry
      vecs[2]  = mk(1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0); // tie even
      vecs[3]  = mk(1'b1, 10'd254, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1'b0); // overflow
      vecs[4]  = mk(1'b0, 10'd0,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0); // underflow
      vecs[5]  = mk(1'b0, 10'd127, 48'h400000000000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1); // nan
      vecs[6]  = mk(1'b1, 10'd127, 48'h400000000000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b0); // -inf
      vecs[7]  = mk(1'b1, 10'd127, 48'h400000000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0); // -0
      vecs[8]  = mk(1'b0, 10'd127, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0); // 1.0
      vecs[9]  = mk(1'b0, 10'd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b0); // tie odd up
      vecs[10] = mk(1'b0, 10'd127, 48'h400000400001, 1'b0, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b0); // sticky up
      vecs[11] = mk(1'b1, 10'd127, 48'h000000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0); // mant 0
      vecs[12] = mk(1'b1, 10'h383, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0); // exp -125
      vecs[13] = mk(1'b0, 10'd1,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0); // min normal
      vecs[14] = mk(1'b0, 10'd254, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0); // round->ovf
      vecs[15] = mk(1'b0, 10'd254, 48'h7FFFFF800000, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0); // max finite
      vecs[16] = mk(1'b0, 10'd127, 48'hC00000800000, 1'b0, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0); // 3.0 tie
      vecs[17] = mk(1'b0, 10'd0,   48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0); // msb rescue

      rst       = 1'b1;
      out_ready = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check_out("reset", mk(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      rst = 1'b0;
      #1;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);

      // ---------------- directed vectors, one at a time ----------------
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         in_valid = 1'b1;
         #1;
         check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
         @(posedge clk);
         #1;
         idle();
         @(negedge clk);
         check($sformatf("v%0d early out_valid", i), {31'd0, out_valid}, 32'd0);
         @(negedge clk);
         check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         check_out($sformatf("v%0d", i), vecs[i]);
      end

      // ---------------- backpressure ----------------
      @(negedge clk);
      out_ready  = 1'b0;
      sent       = 0;
      held_valid = 1'b0;
      held       = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (!held_valid) begin
               held       = result;
               held_valid = 1'b1;
            end else begin
               check($sformatf("bp hold c%0d", c), result, held);
            end
         end
         drive(vecs[sent]);
         in_valid = 1'b1;
         #1;
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      check("bp accepted", sent, 2);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
      check("bp out_valid held", {31'd0, out_valid}, 32'd1);
      check("bp head", result, vecs[0].res);

      out_ready = 1'b1;
      got       = 0;
      last_c    = -1;
      for (int c = 0; c < 12 && got < 4; c++) begin
         @(negedge clk);
         if (sent < 4) begin
            drive(vecs[sent]);
            in_valid = 1'b1;
         end else begin
            idle();
         end
         #1;
         if (out_valid) begin
            check($sformatf("bp out%0d", got), result, vecs[got].res);
            check($sformatf("bp out%0d cycle", got), c, last_c + 1);
            last_c = c;
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      idle();
      check("bp drained", got, 4);
      check("bp all sent", sent, 4);

      // ---------------- reset with both stages full ----------------
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(vecs[4 + k]);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      idle();
      @(negedge clk);
      check("full out_valid", {31'd0, out_valid}, 32'd1);
      check("full in_ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("async rst out_valid", {31'd0, out_valid}, 32'd0);
      check_out("async rst", mk(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      check("async rst in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("post rst out_valid c%0d", c), {31'd0, out_valid}, 32'd0);
         check($sformatf("post rst in_ready c%0d", c), {31'd0, in_ready}, 32'd1);
      end

      // One fresh item after reset still flows correctly.
      @(negedge clk);
      drive(vecs[0]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      @(negedge clk);
      check("post rst item valid", {31'd0, out_valid}, 32'd1);
      check_out("post rst item", vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
